// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control sequencer for the accumulator CPU.
// Walks each instruction through FETCH/DECODE/(MEM|EXEC)/WB phases.
// It drives the PC enable, the IR load and the datapath strobes.
// Outputs are decoded from the state and the internal IR.
// The one exception is the SW completion pcEnable, which follows memReady
// in the same cycle.
//
// Ports:
//   clk, reset (async, active-high), init (sync hold/restart)
//   instruction  : ROM word, captured into IR during FETCH
//   memReady     : data-memory completion, honoured only in MEM
//   pcEnable, irLoad, writeEnable, OP, memRead, memWrite, branch,
//   ALUSrc, MemToReg : datapath control
//   done, memErr : sticky halt / memory-timeout flags, cleared by init
//
// Optional macro CTRL_PERF_CNT_EN adds the cycleCount/instrCount outputs.
// Both are saturating 16-bit counters.
module control_fsm #(
    parameter int unsigned         INSTR_W     = 9,
    parameter int unsigned         OP_W        = 3,
    parameter logic [INSTR_W-1:0]  HALT_WORD   = {INSTR_W{1'b1}},
    parameter int unsigned         MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               memReady,
    output logic               pcEnable,
    output logic               irLoad,
    output logic               writeEnable,
    output logic [OP_W-1:0]    OP,
    output logic               memRead,
    output logic               memWrite,
    output logic               branch,
    output logic               ALUSrc,
    output logic               MemToReg,
    output logic               done,
    output logic               memErr
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]        cycleCount,
    output logic [15:0]        instrCount
`endif
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [OP_W-1:0] opc;
    logic            is_alu, is_lw, is_sw, is_br, is_halt;

    assign opc     = ir_q[INSTR_W-1 -: OP_W];
    assign is_halt = (ir_q == HALT_WORD);
    assign is_alu  = (opc <= OP_W'(4));
    assign is_lw   = (opc == OP_W'(5));
    assign is_sw   = (opc == OP_W'(6));
    assign is_br   = (opc == OP_W'(7));

    // State, IR, timeout counter and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; init overrides every transition
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:   if (!init) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // halt word takes priority over its opcode field
                if (is_halt)            state_d = S_HALT;
                else if (is_alu)        state_d = S_WB;
                else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end
                else if (is_br)         state_d = S_EXEC;
                else                    state_d = S_FETCH;
            end
            S_MEM: begin
                if (memReady) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC:   state_d = S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        if (state_d == S_HALT) done_d = 1'b1;
        if (init) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Output decode from state and IR
    always_comb begin
        pcEnable    = 1'b0;
        irLoad      = 1'b0;
        writeEnable = 1'b0;
        OP          = '0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        branch      = 1'b0;
        ALUSrc      = 1'b0;
        MemToReg    = 1'b0;
        case (state_q)
            S_FETCH:  irLoad = 1'b1;
            S_DECODE: begin
                OP = opc;
                // NOP retires directly from DECODE
                if (!is_halt && !is_alu && !is_lw && !is_sw && !is_br)
                    pcEnable = 1'b1;
            end
            S_MEM: begin
                OP     = opc;
                ALUSrc = 1'b1;
                if (is_lw) begin
                    memRead  = 1'b1;
                    MemToReg = 1'b1;
                end else begin
                    memWrite = 1'b1;
                    pcEnable = memReady;
                end
            end
            S_EXEC: begin
                OP       = opc;
                branch   = 1'b1;
                pcEnable = 1'b1;
            end
            S_WB: begin
                OP          = opc;
                writeEnable = 1'b1;
                pcEnable    = 1'b1;
                if (is_lw) begin
                    MemToReg = 1'b1;
                    ALUSrc   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign done   = done_q;
    assign memErr = err_q;

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] cyc_q, ins_q;

    // Saturating activity counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else if (init) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT && cyc_q != 16'hFFFF)
                cyc_q <= cyc_q + 16'd1;
            if (pcEnable && ins_q != 16'hFFFF)
                ins_q <= ins_q + 16'd1;
        end
    end

    assign cycleCount = cyc_q;
    assign instrCount = ins_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm (default parameters).
// Each instruction is expanded into its expected per-cycle output trace.
module tb_control_fsm;

    localparam int unsigned INSTR_W     = 9;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned MEM_TIMEOUT = 15;

    typedef struct packed {
        logic       pc;
        logic       ir;
        logic       we;
        logic [2:0] op;
        logic       mr;
        logic       mw;
        logic       br;
        logic       src;
        logic       m2r;
        logic       done;
        logic       err;
    } out_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               init;
    logic [INSTR_W-1:0] instruction;
    logic               memReady;
    logic               pcEnable, irLoad, writeEnable;
    logic [OP_W-1:0]    OP;
    logic               memRead, memWrite, branch, ALUSrc, MemToReg, done, memErr;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0]        cycleCount, instrCount;
`endif

    control_fsm #(
        .INSTR_W    (INSTR_W),
        .OP_W       (OP_W),
        .HALT_WORD  (9'h1FF),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .instruction(instruction),
        .memReady   (memReady),
        .pcEnable   (pcEnable),
        .irLoad     (irLoad),
        .writeEnable(writeEnable),
        .OP         (OP),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .branch     (branch),
        .ALUSrc     (ALUSrc),
        .MemToReg   (MemToReg),
        .done       (done),
        .memErr     (memErr)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycleCount (cycleCount),
        .instrCount (instrCount)
`endif
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    logic done_m = 1'b0;
    logic err_m  = 1'b0;
    out_t obs;

    function automatic out_t base();
        out_t e;
        e      = '0;
        e.done = done_m;
        e.err  = err_m;
        return e;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input out_t exp, input string tag);
        obs = {pcEnable, irLoad, writeEnable, OP, memRead, memWrite,
               branch, ALUSrc, MemToReg, done, memErr};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance past the edge
    task automatic cyc(input logic mr, input logic in_init, input out_t exp, input string tag);
        memReady = mr;
        init     = in_init;
        @(negedge clk);
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    // Expected trace of one instruction starting in FETCH.
    // wait_n: not-ready MEM cycles before memReady; abort_at: MEM cycle raising init.
    task automatic run_instr(input logic [8:0] ins, input int wait_n, input int abort_at);
        logic [2:0] opc;
        logic       ready;
        out_t       e;
        opc         = ins[8:6];
        instruction = ins;
        e = base(); e.ir = 1'b1;
        cyc(rnd(), 1'b0, e, "fetch");
        instruction = 9'($urandom_range(0, 511));
        e = base(); e.op = opc;
        cyc(rnd(), 1'b0, e, "decode");
        if (ins == 9'h1FF) begin
            done_m = 1'b1;
            return;
        end
        if (opc <= 3'd4) begin
            e = base(); e.op = opc; e.we = 1'b1; e.pc = 1'b1;
            cyc(rnd(), 1'b0, e, "wb_alu");
        end else if (opc == 3'd7) begin
            e = base(); e.op = opc; e.br = 1'b1; e.pc = 1'b1;
            cyc(rnd(), 1'b0, e, "exec_br");
        end else begin
            for (int k = 0; k < int'(MEM_TIMEOUT); k++) begin
                ready = (k == wait_n);
                e = base(); e.op = opc; e.src = 1'b1;
                if (opc == 3'd5) begin
                    e.mr = 1'b1; e.m2r = 1'b1;
                end else begin
                    e.mw = 1'b1; e.pc = ready;
                end
                if (k == abort_at) begin
                    cyc(ready, 1'b1, e, "mem_init");
                    cyc(rnd(), 1'b0, base(), "idle_after_init");
                    return;
                end
                cyc(ready, 1'b0, e, "mem");
                if (ready) break;
                if (k == int'(MEM_TIMEOUT) - 1) begin
                    done_m = 1'b1;
                    err_m  = 1'b1;
                    return;
                end
            end
            if (opc == 3'd5) begin
                e = base(); e.op = opc; e.we = 1'b1; e.pc = 1'b1;
                e.m2r = 1'b1; e.src = 1'b1;
                cyc(rnd(), 1'b0, e, "wb_lw");
            end
        end
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) cyc(rnd(), 1'b0, base(), "halt_hold");
    endtask

    task automatic restart();
        cyc(rnd(), 1'b1, base(), "halt_init");
        done_m = 1'b0;
        err_m  = 1'b0;
        cyc(rnd(), 1'b0, base(), "idle_restart");
    endtask

    initial begin
        logic [8:0] ins;
        int         w;
        out_t       e;

        reset = 1'b1; init = 1'b1; memReady = 1'b0; instruction = '0;
        #2;
        check(base(), "reset_async");
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b0, 1'b1, base(), "idle_init_hi");
        cyc(1'b1, 1'b1, base(), "idle_init_hi");
        instruction = 9'b100_000001;
        cyc(1'b0, 1'b0, base(), "idle_start");

        run_instr(9'b100_000001, 0, -1);          // ADD
        run_instr(9'b101_000010, 2, -1);          // LW, ready on 3rd MEM cycle
        run_instr(9'b110_000011, 1000, -1);       // SW, timeout
        halt_hold(3);
        restart();
        run_instr(9'b111_000100, 0, -1);          // BR
        run_instr(9'b110_000111, 0, -1);          // SW, immediate ready
        run_instr(9'h1FF, 0, -1);                 // halt word
        halt_hold(20);
        restart();
        run_instr(9'b101_000010, 1000, 1);        // LW aborted by init

        // Asynchronous reset while in WB
        instruction = 9'b000_010101;
        e = base(); e.ir = 1'b1;
        cyc(1'b0, 1'b0, e, "fetch_r");
        e = base(); e.op = 3'd0;
        cyc(1'b0, 1'b0, e, "decode_r");
        memReady = 1'b0;
        @(negedge clk);
        e = base(); e.we = 1'b1; e.pc = 1'b1; e.op = 3'd0;
        check(e, "wb_before_reset");
        #1 reset = 1'b1;
        #1 check(base(), "wb_async_reset");
        init = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b0, 1'b1, base(), "idle_post_reset");
        cyc(1'b0, 1'b0, base(), "idle_post_reset");

        // Random instruction stream with random memory latency
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) ins = 9'h1FF;
            else                           ins = 9'($urandom_range(0, 511));
            w = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(0, 4));
            run_instr(ins, w, -1);
            if (done_m) begin
                halt_hold(int'($urandom_range(1, 3)));
                restart();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
